// File: rtl/pol_max_core.sv
// Max-pooling core: turns neighbour indices into arbiter read requests and
// reduces the in-order returned feature vectors lane-wise by unsigned max.
module pol_max_core #(
    parameter int IDX_WIDTH      = 10,
    parameter int ACT_WIDTH      = 8,
    parameter int POOL_COMP_CORE = 64,
    parameter int K_WIDTH        = 5,
    parameter int PNT_WIDTH      = 16,
    parameter int OUTSTAND       = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                CCUPOL_Start,
    input  logic [K_WIDTH-1:0]                  CCUPOL_K,
    input  logic [PNT_WIDTH-1:0]                CCUPOL_NumPnt,
    output logic                                POLCCU_Done,
    input  logic [IDX_WIDTH-1:0]                MAPPOL_Idx,
    input  logic                                MAPPOL_IdxVld,
    output logic                                POLMAP_IdxRdy,
    output logic                                POLMIF_AddrVld,
    output logic [IDX_WIDTH-1:0]                POLMIF_Addr,
    input  logic                                MIFPOL_Rdy,
    input  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] MIFPOL_Ofm,
    input  logic                                MIFPOL_OfmVld,
    output logic                                POLMIF_OfmRdy,
    output logic [ACT_WIDTH*POOL_COMP_CORE-1:0] POLGLB_Fm,
    output logic                                POLGLB_FmVld,
    input  logic                                GLBPOL_FmRdy
);
    localparam int VEC_W = ACT_WIDTH * POOL_COMP_CORE;
    localparam int TOT_W = K_WIDTH + PNT_WIDTH;
    localparam int CRD_W = $clog2(OUTSTAND) + 1;

    // All handshakes: a transfer happens on a clock edge where valid and ready
    // are both high; valid never depends on the consumer's ready.
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t               state;
    logic [K_WIDTH-1:0]   k_reg;
    logic [K_WIDTH-1:0]   kcnt;
    logic [PNT_WIDTH-1:0] npnt_reg;
    logic [PNT_WIDTH-1:0] pcnt;
    logic [TOT_W-1:0]     total;
    logic [TOT_W-1:0]     issued;
    logic [CRD_W-1:0]     credit;
    logic [VEC_W-1:0]     acc;
    logic [VEC_W-1:0]     max_vec;
    logic [VEC_W-1:0]     beat_vec;
    logic                 busy;
    logic                 issue_en;
    logic                 addr_hs;
    logic                 data_hs;
    logic                 out_hs;
    logic                 first_beat;
    logic                 last_beat;

    assign busy     = (state == BUSY);
    assign total    = TOT_W'(k_reg) * TOT_W'(npnt_reg);
    assign issue_en = busy && (issued < total) && (credit < CRD_W'(OUTSTAND));

    assign POLMIF_Addr    = MAPPOL_Idx;
    assign POLMIF_AddrVld = MAPPOL_IdxVld & issue_en;
    assign POLMAP_IdxRdy  = MIFPOL_Rdy & issue_en;
    assign addr_hs        = POLMIF_AddrVld & MIFPOL_Rdy;

    assign first_beat = (kcnt == '0);
    assign last_beat  = (kcnt == k_reg - K_WIDTH'(1));

    // Final beat may only stall while the output register is full and not draining.
    assign POLMIF_OfmRdy = busy & ~(last_beat & POLGLB_FmVld & ~GLBPOL_FmRdy);
    assign data_hs       = MIFPOL_OfmVld & POLMIF_OfmRdy;
    assign out_hs        = POLGLB_FmVld & GLBPOL_FmRdy;
    assign POLCCU_Done   = (state == DONE);

    always_comb begin
        max_vec = acc;
        for (int i = 0; i < POOL_COMP_CORE; i++) begin
            if (MIFPOL_Ofm[i*ACT_WIDTH +: ACT_WIDTH] > acc[i*ACT_WIDTH +: ACT_WIDTH])
                max_vec[i*ACT_WIDTH +: ACT_WIDTH] = MIFPOL_Ofm[i*ACT_WIDTH +: ACT_WIDTH];
        end
    end

    assign beat_vec = first_beat ? MIFPOL_Ofm : max_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            k_reg        <= '0;
            npnt_reg     <= '0;
            kcnt         <= '0;
            pcnt         <= '0;
            issued       <= '0;
            credit       <= '0;
            acc          <= '0;
            POLGLB_Fm    <= '0;
            POLGLB_FmVld <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (CCUPOL_Start) begin
                        k_reg        <= CCUPOL_K;
                        npnt_reg     <= CCUPOL_NumPnt;
                        kcnt         <= '0;
                        pcnt         <= '0;
                        issued       <= '0;
                        credit       <= '0;
                        POLGLB_FmVld <= 1'b0;
                        state <= (CCUPOL_K == '0 || CCUPOL_NumPnt == '0) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (addr_hs)
                        issued <= issued + TOT_W'(1);
                    if (addr_hs && !data_hs)
                        credit <= credit + CRD_W'(1);
                    else if (!addr_hs && data_hs)
                        credit <= credit - CRD_W'(1);
                    if (data_hs) begin
                        acc <= beat_vec;
                        if (last_beat) begin
                            kcnt <= '0;
                            pcnt <= pcnt + PNT_WIDTH'(1);
                        end else begin
                            kcnt <= kcnt + K_WIDTH'(1);
                        end
                    end
                    // pcnt reaching npnt means the register now holds the last point
                    if (data_hs && last_beat) begin
                        POLGLB_Fm    <= beat_vec;
                        POLGLB_FmVld <= 1'b1;
                    end else if (out_hs) begin
                        POLGLB_FmVld <= 1'b0;
                    end
                    if (out_hs && pcnt == npnt_reg)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pol_max_core.sv
// Directed bench for pol_max_core: index/memory-side driver, output scoreboard
// fed with hand-derived pooled vectors, and a monitor popping on each output.
`timescale 1ns/1ps
module tb_pol_max_core;
    localparam int IW = 10;
    localparam int AW = 8;
    localparam int LN = 64;
    localparam int KW = 5;
    localparam int PW = 16;
    localparam int OS = 4;
    localparam int VW = AW * LN;

    logic          clk;
    logic          rst_n;
    logic          CCUPOL_Start;
    logic [KW-1:0] CCUPOL_K;
    logic [PW-1:0] CCUPOL_NumPnt;
    logic          POLCCU_Done;
    logic [IW-1:0] MAPPOL_Idx;
    logic          MAPPOL_IdxVld;
    logic          POLMAP_IdxRdy;
    logic          POLMIF_AddrVld;
    logic [IW-1:0] POLMIF_Addr;
    logic          MIFPOL_Rdy;
    logic [VW-1:0] MIFPOL_Ofm;
    logic          MIFPOL_OfmVld;
    logic          POLMIF_OfmRdy;
    logic [VW-1:0] POLGLB_Fm;
    logic          POLGLB_FmVld;
    logic          GLBPOL_FmRdy;

    pol_max_core #(
        .IDX_WIDTH(IW), .ACT_WIDTH(AW), .POOL_COMP_CORE(LN),
        .K_WIDTH(KW), .PNT_WIDTH(PW), .OUTSTAND(OS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .CCUPOL_Start(CCUPOL_Start), .CCUPOL_K(CCUPOL_K), .CCUPOL_NumPnt(CCUPOL_NumPnt),
        .POLCCU_Done(POLCCU_Done),
        .MAPPOL_Idx(MAPPOL_Idx), .MAPPOL_IdxVld(MAPPOL_IdxVld), .POLMAP_IdxRdy(POLMAP_IdxRdy),
        .POLMIF_AddrVld(POLMIF_AddrVld), .POLMIF_Addr(POLMIF_Addr), .MIFPOL_Rdy(MIFPOL_Rdy),
        .MIFPOL_Ofm(MIFPOL_Ofm), .MIFPOL_OfmVld(MIFPOL_OfmVld), .POLMIF_OfmRdy(POLMIF_OfmRdy),
        .POLGLB_Fm(POLGLB_Fm), .POLGLB_FmVld(POLGLB_FmVld), .GLBPOL_FmRdy(GLBPOL_FmRdy)
    );

    logic [VW-1:0] mem [0:1023];
    logic [VW-1:0] exp_q[$];
    logic [IW-1:0] idx_q[$];
    logic [IW-1:0] req_q[$];
    int            out_cyc_q[$];

    int total_cnt = 0;
    int bad_cnt   = 0;
    int cyc       = 0;
    int n_addr    = 0;
    int n_data    = 0;
    int out_cnt   = 0;
    int done_cnt  = 0;
    int done_cyc  = 0;
    int last_out_cyc = 0;
    bit mif_rdy   = 1'b1;
    bit ofm_en    = 1'b1;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [VW-1:0] got, input logic [VW-1:0] want);
        total_cnt++;
        if (got !== want) begin
            bad_cnt++;
            $display("FAIL %s: got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic logic [VW-1:0] vmax(input logic [VW-1:0] a, input logic [VW-1:0] b);
        logic [VW-1:0] r;
        r = '0;
        for (int i = 0; i < LN; i++)
            r[i*AW +: AW] = (a[i*AW +: AW] > b[i*AW +: AW]) ? a[i*AW +: AW] : b[i*AW +: AW];
        return r;
    endfunction

    // Index source and memory side: handshakes sampled at negedge, applied after the edge.
    initial begin
        bit            ih;
        bit            ah;
        bit            dh;
        logic [IW-1:0] a;
        MAPPOL_IdxVld = 1'b0;
        MAPPOL_Idx    = '0;
        MIFPOL_Rdy    = 1'b0;
        MIFPOL_OfmVld = 1'b0;
        MIFPOL_Ofm    = '0;
        forever begin
            @(negedge clk);
            ih = MAPPOL_IdxVld && POLMAP_IdxRdy;
            ah = POLMIF_AddrVld && MIFPOL_Rdy;
            dh = MIFPOL_OfmVld && POLMIF_OfmRdy;
            a  = POLMIF_Addr;
            @(posedge clk);
            #2;
            if (ih && idx_q.size() > 0) void'(idx_q.pop_front());
            if (dh && req_q.size() > 0) begin
                void'(req_q.pop_front());
                n_data++;
            end
            if (ah) begin
                req_q.push_back(a);
                n_addr++;
            end
            MAPPOL_IdxVld = (idx_q.size() > 0);
            MAPPOL_Idx    = (idx_q.size() > 0) ? idx_q[0] : '0;
            MIFPOL_Rdy    = mif_rdy;
            MIFPOL_OfmVld = ofm_en && (req_q.size() > 0);
            MIFPOL_Ofm    = (req_q.size() > 0) ? mem[req_q[0]] : '0;
        end
    end

    // Monitor: pops the scoreboard on every pooled-vector handshake.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (POLGLB_FmVld && GLBPOL_FmRdy) begin
                out_cnt++;
                last_out_cyc = cyc;
                out_cyc_q.push_back(cyc);
                check("out_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("pooled_vec", POLGLB_Fm, exp_q.pop_front());
            end
            if (POLCCU_Done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int k, input int np);
        CCUPOL_K      = KW'(k);
        CCUPOL_NumPnt = PW'(np);
        CCUPOL_Start  = 1'b1;
        tick(1);
        CCUPOL_Start  = 1'b0;
    endtask

    task automatic wait_done(input string name, input int d0, input int budget);
        int n;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick(1);
            n++;
        end
        check(name, done_cnt != d0, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"}, POLCCU_Done, 0);
        check({tag, "_fmvld"}, POLGLB_FmVld, 0);
        check({tag, "_fm"}, POLGLB_Fm, 0);
        check({tag, "_idxrdy"}, POLMAP_IdxRdy, 0);
        check({tag, "_addrvld"}, POLMIF_AddrVld, 0);
        check({tag, "_ofmrdy"}, POLMIF_OfmRdy, 0);
    endtask

    initial begin
        logic [VW-1:0] e;
        int d0;
        int a0;
        int o0;
        int n0;
        int n;

        for (int a = 0; a < 1024; a++)
            for (int i = 0; i < LN; i++)
                mem[a][i*AW +: AW] = AW'((a * 37 + i * 11) ^ (i * 5));
        mem[1] = '0; mem[1][7:0] = 8'd5;
        mem[2] = '0; mem[2][7:0] = 8'd200;
        mem[3] = '0; mem[3][7:0] = 8'd17;

        rst_n = 1'b0;
        CCUPOL_Start = 1'b0;
        CCUPOL_K = '0;
        CCUPOL_NumPnt = '0;
        GLBPOL_FmRdy = 1'b1;
        tick(3);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick(2);

        // K=3, one point: lane0 max of 5,200,17
        e = '0;
        e[7:0] = 8'd200;
        exp_q.push_back(e);
        for (int a = 1; a <= 3; a++) idx_q.push_back(IW'(a));
        d0 = done_cnt; o0 = out_cnt;
        start_run(3, 1);
        wait_done("k3_done_seen", d0, 100);
        check("k3_done_after_out", done_cyc - last_out_cyc, 1);
        tick(3);
        check("k3_done_pulses", done_cnt - d0, 1);
        check("k3_out_count", out_cnt - o0, 1);

        // K=1, four points back to back
        for (int a = 10; a <= 13; a++) begin
            idx_q.push_back(IW'(a));
            exp_q.push_back(mem[a]);
        end
        d0 = done_cnt; o0 = out_cnt; a0 = n_addr;
        tick(1);
        start_run(1, 4);
        wait_done("k1_done_seen", d0, 100);
        tick(2);
        check("k1_addr_count", n_addr - a0, 4);
        check("k1_out_count", out_cnt - o0, 4);
        check("k1_consecutive", out_cyc_q[out_cyc_q.size()-1] - out_cyc_q[out_cyc_q.size()-4], 3);

        // credit limit with data withheld
        e = mem[30];
        for (int a = 30; a <= 37; a++) begin
            idx_q.push_back(IW'(a));
            e = vmax(e, mem[a]);
        end
        exp_q.push_back(e);
        ofm_en = 1'b0;
        d0 = done_cnt; a0 = n_addr; n0 = n_data;
        tick(1);
        start_run(8, 1);
        tick(10);
        check("credit_addr_cap", n_addr - a0, OS);
        check("credit_idxrdy_low", POLMAP_IdxRdy, 0);
        ofm_en = 1'b1;
        tick(1);
        ofm_en = 1'b0;
        tick(6);
        check("credit_one_data", n_data - n0, 1);
        check("credit_one_more_addr", n_addr - a0, OS + 1);
        check("credit_idxrdy_low2", POLMAP_IdxRdy, 0);
        ofm_en = 1'b1;
        wait_done("credit_done_seen", d0, 200);
        tick(2);

        // K=2, two points, output held back
        exp_q.push_back(vmax(mem[20], mem[21]));
        exp_q.push_back(vmax(mem[22], mem[23]));
        for (int a = 20; a <= 23; a++) idx_q.push_back(IW'(a));
        GLBPOL_FmRdy = 1'b0;
        d0 = done_cnt; a0 = n_addr; n0 = n_data; o0 = out_cnt;
        tick(1);
        start_run(2, 2);
        tick(20);
        check("hold_vld", POLGLB_FmVld, 1);
        check("hold_vec", POLGLB_Fm, vmax(mem[20], mem[21]));
        check("hold_data_beats", n_data - n0, 3);
        check("hold_final_ofmvld", MIFPOL_OfmVld, 1);
        check("hold_final_ofmrdy", POLMIF_OfmRdy, 0);
        start_run(1, 1);
        tick(3);
        check("busy_start_ignored", n_addr - a0, 4);
        GLBPOL_FmRdy = 1'b1;
        wait_done("hold_done_seen", d0, 100);
        tick(3);
        check("hold_out_count", out_cnt - o0, 2);
        check("hold_done_pulses", done_cnt - d0, 1);

        // degenerate runs: K=0 and NumPnt=0
        idx_q.push_back(IW'(60));
        d0 = done_cnt; a0 = n_addr;
        tick(1);
        start_run(0, 5);
        check("k0_done_next", POLCCU_Done, 1);
        tick(3);
        start_run(3, 0);
        check("np0_done_next", POLCCU_Done, 1);
        tick(3);
        check("zero_run_addr", n_addr - a0, 0);
        check("zero_run_done_pulses", done_cnt - d0, 2);
        idx_q.delete();
        tick(2);

        // reset during a three-point run, then a fresh run
        for (int p = 0; p < 3; p++)
            exp_q.push_back(vmax(mem[40 + 2*p], mem[41 + 2*p]));
        for (int a = 40; a <= 45; a++) idx_q.push_back(IW'(a));
        o0 = out_cnt;
        tick(1);
        start_run(2, 3);
        n = 0;
        while (out_cnt == o0 && n < 200) begin
            tick(1);
            n++;
        end
        check("rst_first_out_seen", out_cnt != o0, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        tick(2);
        idx_q.delete();
        req_q.delete();
        exp_q.delete();
        tick(1);
        rst_n = 1'b1;
        tick(2);
        exp_q.push_back(vmax(mem[50], mem[51]));
        idx_q.push_back(IW'(50));
        idx_q.push_back(IW'(51));
        d0 = done_cnt; o0 = out_cnt;
        tick(1);
        start_run(2, 1);
        wait_done("post_reset_done_seen", d0, 100);
        tick(3);
        check("post_reset_out_count", out_cnt - o0, 1);
        check("post_reset_exp_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule
